// File: rtl/bus_mem_slave_pkg.sv
// Shared definitions for the bus memory slave: bus polarities, word width
// and the responder state encoding.
package bus_mem_slave_pkg;

   localparam logic READ     = 1'b1;
   localparam logic WRITE    = 1'b0;
   localparam logic ENABLE_  = 1'b0;
   localparam logic DISABLE_ = 1'b1;

   localparam int WORD_DATA_W = 32;
   localparam int WAIT_CNT_W  = 4;

   typedef enum logic [1:0] {
      BUS_SLV_IDLE = 2'd0,
      BUS_SLV_WAIT = 2'd1,
      BUS_SLV_RESP = 2'd2
   } bus_slv_state_e;

endpackage

// File: rtl/bus_mem_slave_ram.sv
// Single-port synchronous word RAM with write enable and a registered read
// port. The read register is cleared whenever no read is issued, so its
// output can be driven straight onto the OR-combined bus.
module bus_mem_slave_ram
   import bus_mem_slave_pkg::*;
#(
   parameter int ADDR_W = 10
) (
   input  logic                   clk,
   input  logic                   we_i,
   input  logic                   rd_en_i,
   input  logic [ADDR_W-1:0]      addr_i,
   input  logic [WORD_DATA_W-1:0] wr_data_i,
   output logic [WORD_DATA_W-1:0] rd_data_o
);

   logic [WORD_DATA_W-1:0] mem_q [0:(1 << ADDR_W)-1];
   logic [WORD_DATA_W-1:0] rd_data_q;

   // Write port; contents are never cleared.
   always_ff @(posedge clk) begin
      if (we_i) begin
         mem_q[addr_i] <= wr_data_i;
      end
   end

   // Read register: RAM word on a read, zero otherwise.
   always_ff @(posedge clk) begin
      if (rd_en_i) begin
         rd_data_q <= mem_q[addr_i];
      end else begin
         rd_data_q <= '0;
      end
   end

   assign rd_data_o = rd_data_q;

endmodule

// File: rtl/bus_mem_slave.sv
// Bus-side memory responder: accepts a single-cycle strobe in IDLE, waits
// WAIT_CYCLES cycles, then answers with a one-cycle active-low rdy_.
// The RAM is written / read on the edge that enters RESP, so the access
// always lines up with the rdy_ cycle.
module bus_mem_slave
   import bus_mem_slave_pkg::*;
#(
   parameter int ADDR_W      = 10,
   parameter int WAIT_CYCLES = 1
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   cs_,
   input  logic                   as_,
   input  logic                   rw,
   input  logic [ADDR_W-1:0]      addr,
   input  logic [WORD_DATA_W-1:0] wr_data,
   output logic [WORD_DATA_W-1:0] rd_data,
   output logic                   rdy_,
   output logic                   busy
);

   localparam logic [WAIT_CNT_W-1:0] WAIT_INIT = WAIT_CNT_W'(WAIT_CYCLES);

   bus_slv_state_e         state_q;
   logic [WAIT_CNT_W-1:0]  cnt_q;
   logic                   rdy_q;
   logic                   busy_q;
   logic [ADDR_W-1:0]      addr_q;
   logic                   rw_q;
   logic [WORD_DATA_W-1:0] wr_data_q;

   logic                   accept;
   logic                   enter_resp;
   logic [ADDR_W-1:0]      req_addr_d;
   logic                   req_rw_d;
   logic [WORD_DATA_W-1:0] req_wr_data_d;
   logic                   ram_we;
   logic                   ram_rd;

   assign accept = (state_q == BUS_SLV_IDLE) && (cs_ == ENABLE_) && (as_ == ENABLE_);

   // With zero wait states RESP is entered on the accepting edge itself.
   assign enter_resp = (accept && (WAIT_INIT == '0)) ||
                       ((state_q == BUS_SLV_WAIT) && (cnt_q == WAIT_CNT_W'(1)));

   // In IDLE the request comes straight from the bus, otherwise from the latches.
   assign req_addr_d    = (state_q == BUS_SLV_IDLE) ? addr    : addr_q;
   assign req_rw_d      = (state_q == BUS_SLV_IDLE) ? rw      : rw_q;
   assign req_wr_data_d = (state_q == BUS_SLV_IDLE) ? wr_data : wr_data_q;

   // Reset on the RESP-entry edge suppresses the access entirely.
   assign ram_we = enter_resp && !reset && (req_rw_d == WRITE);
   assign ram_rd = enter_resp && !reset && (req_rw_d == READ);

   // Responder FSM with registered rdy_/busy.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= BUS_SLV_IDLE;
         cnt_q   <= '0;
         rdy_q   <= DISABLE_;
         busy_q  <= 1'b0;
      end else begin
         case (state_q)
            BUS_SLV_IDLE: begin
               rdy_q <= DISABLE_;
               if (accept) begin
                  busy_q <= 1'b1;
                  if (WAIT_INIT == '0) begin
                     state_q <= BUS_SLV_RESP;
                     rdy_q   <= ENABLE_;
                  end else begin
                     state_q <= BUS_SLV_WAIT;
                     cnt_q   <= WAIT_INIT;
                  end
               end
            end
            BUS_SLV_WAIT: begin
               if (cnt_q == WAIT_CNT_W'(1)) begin
                  state_q <= BUS_SLV_RESP;
                  cnt_q   <= '0;
                  rdy_q   <= ENABLE_;
               end else begin
                  cnt_q <= cnt_q - WAIT_CNT_W'(1);
               end
            end
            BUS_SLV_RESP: begin
               state_q <= BUS_SLV_IDLE;
               rdy_q   <= DISABLE_;
               busy_q  <= 1'b0;
            end
            default: begin
               state_q <= BUS_SLV_IDLE;
               cnt_q   <= '0;
               rdy_q   <= DISABLE_;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   // Request latches; only loaded on an accepted strobe.
   always_ff @(posedge clk) begin
      if (accept && !reset) begin
         addr_q    <= addr;
         rw_q      <= rw;
         wr_data_q <= wr_data;
      end
   end

   bus_mem_slave_ram #(
      .ADDR_W (ADDR_W)
   ) u_ram (
      .clk       (clk),
      .we_i      (ram_we),
      .rd_en_i   (ram_rd),
      .addr_i    (req_addr_d),
      .wr_data_i (req_wr_data_d),
      .rd_data_o (rd_data)
   );

   assign rdy_ = rdy_q;
   assign busy = busy_q;

endmodule

// File: tb/tb_bus_mem_slave.sv
// Directed bench for bus_mem_slave. Three instances share clock and reset:
// index 0 -> WAIT_CYCLES=0, index 1 -> WAIT_CYCLES=1, index 2 -> WAIT_CYCLES=3.
module tb_bus_mem_slave;

   logic        clk = 1'b0;
   logic        reset;
   logic        cs_b    [3];
   logic        as_b    [3];
   logic        rw_b    [3];
   logic [9:0]  addr_b  [3];
   logic [31:0] wdat_b  [3];
   logic [31:0] rdat_b  [3];
   logic        rdy_b   [3];
   logic        busy_b  [3];

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   bus_mem_slave #(.ADDR_W(10), .WAIT_CYCLES(0)) u_w0 (
      .clk(clk), .reset(reset), .cs_(cs_b[0]), .as_(as_b[0]), .rw(rw_b[0]),
      .addr(addr_b[0]), .wr_data(wdat_b[0]), .rd_data(rdat_b[0]),
      .rdy_(rdy_b[0]), .busy(busy_b[0]));

   bus_mem_slave #(.ADDR_W(10), .WAIT_CYCLES(1)) u_w1 (
      .clk(clk), .reset(reset), .cs_(cs_b[1]), .as_(as_b[1]), .rw(rw_b[1]),
      .addr(addr_b[1]), .wr_data(wdat_b[1]), .rd_data(rdat_b[1]),
      .rdy_(rdy_b[1]), .busy(busy_b[1]));

   bus_mem_slave #(.ADDR_W(10), .WAIT_CYCLES(3)) u_w3 (
      .clk(clk), .reset(reset), .cs_(cs_b[2]), .as_(as_b[2]), .rw(rw_b[2]),
      .addr(addr_b[2]), .wr_data(wdat_b[2]), .rd_data(rdat_b[2]),
      .rdy_(rdy_b[2]), .busy(busy_b[2]));

   task automatic drive(input int k, input logic c, input logic a, input logic r,
                        input logic [9:0] ad, input logic [31:0] d);
      cs_b[k] = c; as_b[k] = a; rw_b[k] = r; addr_b[k] = ad; wdat_b[k] = d;
   endtask

   task automatic idle(input int k);
      drive(k, 1'b1, 1'b1, 1'b1, 10'h000, 32'h0);
   endtask

   // Strobe one request, release it, and run past its response (lat = WAIT_CYCLES+1).
   task automatic do_write(input int k, input logic [9:0] ad, input logic [31:0] d, input int lat);
      drive(k, 1'b0, 1'b0, 1'b0, ad, d);
      @(posedge clk); #1 idle(k);
      repeat (lat + 1) @(negedge clk);
   endtask

   task automatic test_reset();
      reset = 1'b1;
      for (int k = 0; k < 3; k++) idle(k);
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         for (int k = 0; k < 3; k++) begin
            checks++; if (rdy_b[k] !== 1'b1) begin failures++; $display("FAIL reset_rdy k=%0d c=%0d got=%b exp=1", k, c, rdy_b[k]); end
            checks++; if (busy_b[k] !== 1'b0) begin failures++; $display("FAIL reset_busy k=%0d c=%0d got=%b exp=0", k, c, busy_b[k]); end
            checks++; if (rdat_b[k] !== 32'h0) begin failures++; $display("FAIL reset_rdata k=%0d c=%0d got=%h exp=0", k, c, rdat_b[k]); end
         end
      end
   endtask

   task automatic test_write_read_w1();
      logic        er, eb;
      logic [31:0] ed;
      // write 0xDEADBEEF @0x005: rdy_ only at t+2
      drive(1, 1'b0, 1'b0, 1'b0, 10'h005, 32'hDEADBEEF);
      @(posedge clk); #1 idle(1);
      for (int i = 1; i <= 3; i++) begin
         @(negedge clk);
         er = (i == 2) ? 1'b0 : 1'b1; eb = (i <= 2); ed = 32'h0;
         checks++; if (rdy_b[1] !== er) begin failures++; $display("FAIL w1_write_rdy i=%0d got=%b exp=%b", i, rdy_b[1], er); end
         checks++; if (busy_b[1] !== eb) begin failures++; $display("FAIL w1_write_busy i=%0d got=%b exp=%b", i, busy_b[1], eb); end
         checks++; if (rdat_b[1] !== ed) begin failures++; $display("FAIL w1_write_rdata i=%0d got=%h exp=%h", i, rdat_b[1], ed); end
      end
      // read @0x005: data at t'+2, zero the following cycle
      drive(1, 1'b0, 1'b0, 1'b1, 10'h005, 32'h0);
      @(posedge clk); #1 idle(1);
      for (int i = 1; i <= 3; i++) begin
         @(negedge clk);
         er = (i == 2) ? 1'b0 : 1'b1; eb = (i <= 2); ed = (i == 2) ? 32'hDEADBEEF : 32'h0;
         checks++; if (rdy_b[1] !== er) begin failures++; $display("FAIL w1_read_rdy i=%0d got=%b exp=%b", i, rdy_b[1], er); end
         checks++; if (busy_b[1] !== eb) begin failures++; $display("FAIL w1_read_busy i=%0d got=%b exp=%b", i, busy_b[1], eb); end
         checks++; if (rdat_b[1] !== ed) begin failures++; $display("FAIL w1_read_rdata i=%0d got=%h exp=%h", i, rdat_b[1], ed); end
      end
   endtask

   task automatic test_back_to_back_w0();
      logic [9:0]  ra [3];
      logic [31:0] rd [3];
      ra[0] = 10'h000; rd[0] = 32'h11110000;
      ra[1] = 10'h3FF; rd[1] = 32'h2222FFFF;
      ra[2] = 10'h000; rd[2] = 32'h11110000;
      do_write(0, 10'h000, 32'h11110000, 1);
      do_write(0, 10'h3FF, 32'h2222FFFF, 1);
      for (int j = 0; j < 3; j++) begin
         drive(0, 1'b0, 1'b0, 1'b1, ra[j], 32'h0);
         @(posedge clk); #1 idle(0);
         @(negedge clk);
         checks++; if (rdy_b[0] !== 1'b0) begin failures++; $display("FAIL b2b_rdy j=%0d got=%b exp=0", j, rdy_b[0]); end
         checks++; if (busy_b[0] !== 1'b1) begin failures++; $display("FAIL b2b_busy j=%0d got=%b exp=1", j, busy_b[0]); end
         checks++; if (rdat_b[0] !== rd[j]) begin failures++; $display("FAIL b2b_rdata j=%0d got=%h exp=%h", j, rdat_b[0], rd[j]); end
         @(negedge clk);
         checks++; if (rdy_b[0] !== 1'b1) begin failures++; $display("FAIL b2b_rdy_after j=%0d got=%b exp=1", j, rdy_b[0]); end
         checks++; if (busy_b[0] !== 1'b0) begin failures++; $display("FAIL b2b_busy_after j=%0d got=%b exp=0", j, busy_b[0]); end
         checks++; if (rdat_b[0] !== 32'h0) begin failures++; $display("FAIL b2b_rdata_after j=%0d got=%h exp=0", j, rdat_b[0]); end
      end
   endtask

   task automatic test_ignore_strobe_w3();
      logic        er, eb;
      logic [31:0] ed;
      do_write(2, 10'h011, 32'hA5A50011, 4);
      do_write(2, 10'h010, 32'h00005555, 4);
      // read @0x011; a write strobe is held through WAIT and RESP
      drive(2, 1'b0, 1'b0, 1'b1, 10'h011, 32'h0);
      @(posedge clk); #1 idle(2);
      for (int i = 1; i <= 7; i++) begin
         @(negedge clk);
         er = (i == 4) ? 1'b0 : 1'b1; eb = (i <= 4); ed = (i == 4) ? 32'hA5A50011 : 32'h0;
         checks++; if (rdy_b[2] !== er) begin failures++; $display("FAIL w3_rdy i=%0d got=%b exp=%b", i, rdy_b[2], er); end
         checks++; if (busy_b[2] !== eb) begin failures++; $display("FAIL w3_busy i=%0d got=%b exp=%b", i, busy_b[2], eb); end
         checks++; if (rdat_b[2] !== ed) begin failures++; $display("FAIL w3_rdata i=%0d got=%h exp=%h", i, rdat_b[2], ed); end
         if (i == 1) drive(2, 1'b0, 1'b0, 1'b0, 10'h010, 32'h00001234);
         if (i == 4) idle(2);
      end
      // RAM[0x010] must still hold the preloaded word
      drive(2, 1'b0, 1'b0, 1'b1, 10'h010, 32'h0);
      @(posedge clk); #1 idle(2);
      for (int i = 1; i <= 5; i++) begin
         @(negedge clk);
         er = (i == 4) ? 1'b0 : 1'b1; ed = (i == 4) ? 32'h00005555 : 32'h0;
         checks++; if (rdy_b[2] !== er) begin failures++; $display("FAIL w3_readback_rdy i=%0d got=%b exp=%b", i, rdy_b[2], er); end
         checks++; if (rdat_b[2] !== ed) begin failures++; $display("FAIL w3_readback_rdata i=%0d got=%h exp=%h", i, rdat_b[2], ed); end
      end
   endtask

   task automatic test_reset_abort();
      logic        er;
      logic [31:0] ed;
      do_write(1, 10'h020, 32'h0BADF00D, 2);
      drive(1, 1'b0, 1'b0, 1'b0, 10'h020, 32'hCAFE0001);
      @(posedge clk); #1 idle(1);
      @(negedge clk);
      checks++; if (busy_b[1] !== 1'b1) begin failures++; $display("FAIL abort_busy_pre got=%b exp=1", busy_b[1]); end
      checks++; if (rdy_b[1] !== 1'b1) begin failures++; $display("FAIL abort_rdy_pre got=%b exp=1", rdy_b[1]); end
      // reset lands on the edge that would enter RESP
      reset = 1'b1;
      @(posedge clk); #1 reset = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         checks++; if (rdy_b[1] !== 1'b1) begin failures++; $display("FAIL abort_rdy i=%0d got=%b exp=1", i, rdy_b[1]); end
         checks++; if (busy_b[1] !== 1'b0) begin failures++; $display("FAIL abort_busy i=%0d got=%b exp=0", i, busy_b[1]); end
         checks++; if (rdat_b[1] !== 32'h0) begin failures++; $display("FAIL abort_rdata i=%0d got=%h exp=0", i, rdat_b[1]); end
      end
      drive(1, 1'b0, 1'b0, 1'b1, 10'h020, 32'h0);
      @(posedge clk); #1 idle(1);
      for (int i = 1; i <= 3; i++) begin
         @(negedge clk);
         er = (i == 2) ? 1'b0 : 1'b1; ed = (i == 2) ? 32'h0BADF00D : 32'h0;
         checks++; if (rdy_b[1] !== er) begin failures++; $display("FAIL abort_readback_rdy i=%0d got=%b exp=%b", i, rdy_b[1], er); end
         checks++; if (rdat_b[1] !== ed) begin failures++; $display("FAIL abort_readback_rdata i=%0d got=%h exp=%h", i, rdat_b[1], ed); end
      end
   endtask

   task automatic test_cs_deselect();
      logic        er;
      logic [31:0] ed;
      do_write(1, 10'h030, 32'h30303030, 2);
      drive(1, 1'b1, 1'b0, 1'b0, 10'h030, 32'hFFFFFFFF);
      @(posedge clk); #1 idle(1);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         checks++; if (rdy_b[1] !== 1'b1) begin failures++; $display("FAIL cs_rdy i=%0d got=%b exp=1", i, rdy_b[1]); end
         checks++; if (busy_b[1] !== 1'b0) begin failures++; $display("FAIL cs_busy i=%0d got=%b exp=0", i, busy_b[1]); end
      end
      drive(1, 1'b0, 1'b0, 1'b1, 10'h030, 32'h0);
      @(posedge clk); #1 idle(1);
      for (int i = 1; i <= 3; i++) begin
         @(negedge clk);
         er = (i == 2) ? 1'b0 : 1'b1; ed = (i == 2) ? 32'h30303030 : 32'h0;
         checks++; if (rdy_b[1] !== er) begin failures++; $display("FAIL cs_readback_rdy i=%0d got=%b exp=%b", i, rdy_b[1], er); end
         checks++; if (rdat_b[1] !== ed) begin failures++; $display("FAIL cs_readback_rdata i=%0d got=%h exp=%h", i, rdat_b[1], ed); end
      end
   endtask

   initial begin
      test_reset();
      test_write_read_w1();
      test_back_to_back_w0();
      test_ignore_strobe_w3();
      test_reset_abort();
      test_cs_deselect();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
